// File: rtl/wgt_loader_pkg.sv
// Shared weight-path definitions: default geometry of the weight memory and the
// loader FSM state encoding, so the loader and the weight memory agree on them.
package wgt_loader_pkg;

    localparam int unsigned WgtDataWidth = 8;  // bits per weight
    localparam int unsigned WgtRowNum    = 6;  // weights per memory row
    localparam int unsigned WgtAddrWidth = 7;  // 128-row weight memory

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFill  = 2'd1,
        StWrite = 2'd2,
        StDone  = 2'd3
    } wgt_state_e;

    // Counter width able to index n lanes; never narrower than one bit.
    function automatic int unsigned lane_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wgt_row_packer.sv
// Packs a stream of weights into one memory row, first weight in the LSBs.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : drop any partial row (lane counter back to 0)
//   push_i        : accept data_i into the current lane
//   data_i        : incoming weight
//   last_o        : current lane is the final lane of the row
//   row_o         : packed row register
module wgt_row_packer
    import wgt_loader_pkg::*;
#(
    parameter int unsigned DataWidth = WgtDataWidth,
    parameter int unsigned RowNum    = WgtRowNum
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clear_i,
    input  logic                          push_i,
    input  logic [DataWidth-1:0]          data_i,
    output logic                          last_o,
    output logic [RowNum*DataWidth-1:0]   row_o
);

    localparam int unsigned LaneW = lane_width(RowNum);

    logic [LaneW-1:0]              lane_q;
    logic [RowNum*DataWidth-1:0]   row_q;

    assign last_o = (lane_q == LaneW'(RowNum - 1));
    assign row_o  = row_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lane_q <= '0;
            row_q  <= '0;
        end else if (clear_i) begin
            // Stale lanes need no clearing: every lane is rewritten before the next write.
            lane_q <= '0;
        end else if (push_i) begin
            for (int k = 0; k < int'(RowNum); k++) begin
                if (lane_q == LaneW'(k)) begin
                    row_q[k*DataWidth +: DataWidth] <= data_i;
                end
            end
            lane_q <= last_o ? '0 : lane_q + LaneW'(1);
        end
    end

endmodule

// File: rtl/wgt_loader.sv
// Weight loader: streams weights in, packs ROW_NUM of them per row and writes
// consecutive rows into the weight memory starting at a base address.
// Ports:
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_start, i_base_addr,
//   i_row_cnt               : load request (sampled only in IDLE)
//   i_abort                 : cancel a load in progress (beats i_valid)
//   i_data, i_valid, o_ready: weight stream handshake
//   o_wr_en, o_wr_addr,
//   o_wr_data               : weight-memory write port
//   o_busy, o_done          : status
module wgt_loader
    import wgt_loader_pkg::*;
#(
    parameter int DATA_WIDTH    = WgtDataWidth,
    parameter int ROW_NUM       = WgtRowNum,
    parameter int ADDR_WIDTH    = WgtAddrWidth,
    parameter int ROW_WGT_WIDTH = DATA_WIDTH * ROW_NUM
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    input  logic [ADDR_WIDTH-1:0]    i_base_addr,
    input  logic [ADDR_WIDTH-1:0]    i_row_cnt,
    input  logic                     i_abort,
    input  logic [DATA_WIDTH-1:0]    i_data,
    input  logic                     i_valid,
    output logic                     o_ready,
    output logic                     o_wr_en,
    output logic [ADDR_WIDTH-1:0]    o_wr_addr,
    output logic [ROW_WGT_WIDTH-1:0] o_wr_data,
    output logic                     o_busy,
    output logic                     o_done
);

    wgt_state_e               state_q;
    logic [ADDR_WIDTH-1:0]    addr_q;
    logic [ADDR_WIDTH-1:0]    rows_q;
    logic [ADDR_WIDTH-1:0]    wr_addr_q;
    logic [ROW_WGT_WIDTH-1:0] wr_data_q;

    logic                     push;
    logic                     clear;
    logic                     lane_last;
    logic                     wr_fire;
    logic [ROW_WGT_WIDTH-1:0] row;

    assign push    = (state_q == StFill) && i_valid && !i_abort;
    assign clear   = i_abort || (state_q == StIdle);
    assign wr_fire = (state_q == StWrite) && !i_abort;

    wgt_row_packer #(
        .DataWidth (DATA_WIDTH),
        .RowNum    (ROW_NUM)
    ) u_packer (
        .clk_i   (i_clk),
        .rst_ni  (i_rst_n),
        .clear_i (clear),
        .push_i  (push),
        .data_i  (i_data),
        .last_o  (lane_last),
        .row_o   (row)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            rows_q    <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (i_start) begin
                        addr_q  <= i_base_addr;
                        rows_q  <= i_row_cnt;
                        state_q <= (i_row_cnt == '0) ? StDone : StFill;
                    end
                end
                StFill: begin
                    if (i_abort) begin
                        state_q <= StIdle;
                    end else if (push && lane_last) begin
                        state_q <= StWrite;
                    end
                end
                StWrite: begin
                    if (i_abort) begin
                        state_q <= StIdle;
                    end else begin
                        // Capture the written row so the port holds it between writes.
                        wr_addr_q <= addr_q;
                        wr_data_q <= row;
                        addr_q    <= addr_q + ADDR_WIDTH'(1);
                        rows_q    <= rows_q - ADDR_WIDTH'(1);
                        state_q   <= (rows_q == ADDR_WIDTH'(1)) ? StDone : StFill;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign o_ready   = (state_q == StFill);
    assign o_busy    = (state_q == StFill) || (state_q == StWrite);
    assign o_done    = (state_q == StDone);
    assign o_wr_en   = wr_fire;
    // Live values during the write cycle, held copies otherwise (an aborted write
    // therefore never disturbs the port).
    assign o_wr_addr = wr_fire ? addr_q : wr_addr_q;
    assign o_wr_data = wr_fire ? row : wr_data_q;

endmodule

// File: tb/tb_wgt_loader.sv
module tb_wgt_loader;

    localparam int DW = 8;
    localparam int RN = 6;
    localparam int AW = 7;
    localparam int RW = DW * RN;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic [AW-1:0] i_base_addr = '0;
    logic [AW-1:0] i_row_cnt = '0;
    logic          i_abort = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic          o_wr_en;
    logic [AW-1:0] o_wr_addr;
    logic [RW-1:0] o_wr_data;
    logic          o_busy;
    logic          o_done;

    wgt_loader dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_base_addr (i_base_addr),
        .i_row_cnt   (i_row_cnt),
        .i_abort     (i_abort),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .o_wr_en     (o_wr_en),
        .o_wr_addr   (o_wr_addr),
        .o_wr_data   (o_wr_data),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [RW-1:0] data;
        int            cyc;
    } wr_t;

    wr_t exp_wr[$];
    int  exp_done[$];
    int  checks = 0;
    int  errors = 0;
    wr_t mon_e;
    int  mon_d;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Monitor: compares every write / done pulse against the scoreboard.
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_wr_en) begin
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write cyc=%0d addr=%0d data=%h", cyc, o_wr_addr,
                             o_wr_data);
                end else begin
                    mon_e = exp_wr.pop_front();
                    if (o_wr_addr !== mon_e.addr || o_wr_data !== mon_e.data ||
                        cyc != mon_e.cyc) begin
                        errors++;
                        $display("FAIL write got addr=%0d data=%h cyc=%0d exp addr=%0d data=%h cyc=%0d",
                                 o_wr_addr, o_wr_data, cyc, mon_e.addr, mon_e.data, mon_e.cyc);
                    end
                end
            end
            if (o_done) begin
                checks++;
                if (exp_done.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done cyc=%0d", cyc);
                end else begin
                    mon_d = exp_done.pop_front();
                    if (cyc != mon_d) begin
                        errors++;
                        $display("FAIL done_cycle got=%0d exp=%0d", cyc, mon_d);
                    end
                end
            end
        end
    end

    // One load. Reference: row r goes to (base+r) mod 128, byte k of a row at bits
    // [8k+:8]; the write shows up the cycle after the last byte, done the cycle after.
    task automatic run_load(input int base, input int cnt, input bit seq, input bit gaps,
                            input int abort_after, input int rst_row, input bit start_glitch);
        logic [RW-1:0] row;
        logic [DW-1:0] b;
        int            idx;
        int            tries;
        bit            hs;
        row = '0;
        idx = 0;
        i_start = 1'b1;
        i_base_addr = AW'(base);
        i_row_cnt = AW'(cnt);
        if (cnt == 0) exp_done.push_back(cyc + 1);
        step();
        i_start = 1'b0;
        if (cnt == 0) begin
            chk("cnt0_busy_a", {63'd0, o_busy}, 64'd0);
            step();
            chk("cnt0_busy_b", {63'd0, o_busy}, 64'd0);
            step();
            return;
        end
        for (int r = 0; r < cnt; r++) begin
            row = '0;
            for (int k = 0; k < RN; k++) begin
                b = seq ? DW'(idx + 1) : DW'($urandom);
                if (idx == abort_after) begin
                    i_valid = 1'b1;
                    i_data = b;
                    i_abort = 1'b1;
                    step();
                    i_abort = 1'b0;
                    i_valid = 1'b0;
                    chk("abort_busy", {63'd0, o_busy}, 64'd0);
                    chk("abort_ready", {63'd0, o_ready}, 64'd0);
                    step();
                    step();
                    return;
                end
                idx++;
                if (gaps) begin
                    repeat ($urandom_range(0, 3)) begin
                        i_valid = 1'b0;
                        step();
                    end
                end
                hs = 1'b0;
                tries = 0;
                while (!hs) begin
                    i_valid = 1'b1;
                    i_data = b;
                    if (start_glitch && r == 0 && k == 2) begin
                        i_start = 1'b1;
                        i_base_addr = AW'(50);
                        i_row_cnt = AW'(0);
                    end
                    hs = o_ready;
                    step();
                    i_start = 1'b0;
                    tries++;
                    if (!hs && tries > 20) begin
                        checks++;
                        errors++;
                        $display("FAIL ready_timeout row=%0d byte=%0d", r, k);
                        i_valid = 1'b0;
                        return;
                    end
                end
                row[k*DW +: DW] = b;
            end
            if (r == rst_row) begin
                chk("wr_en_before_rst", {63'd0, o_wr_en}, 64'd1);
                i_valid = 1'b0;
                i_rst_n = 1'b0;
                #1;
                chk("rst_wr_en", {63'd0, o_wr_en}, 64'd0);
                chk("rst_ready", {63'd0, o_ready}, 64'd0);
                chk("rst_busy", {63'd0, o_busy}, 64'd0);
                chk("rst_done", {63'd0, o_done}, 64'd0);
                chk("rst_addr", 64'(o_wr_addr), 64'd0);
                chk("rst_data", 64'(o_wr_data), 64'd0);
                step();
                i_rst_n = 1'b1;
                step();
                step();
                chk("post_rst_busy", {63'd0, o_busy}, 64'd0);
                return;
            end
            exp_wr.push_back('{addr: AW'((base + r) % 128), data: row, cyc: cyc});
            if (r == cnt - 1) exp_done.push_back(cyc + 1);
        end
        i_valid = 1'b0;
        step();
        step();
        chk("hold_addr", 64'(o_wr_addr), 64'((base + cnt - 1) % 128));
        chk("hold_data", 64'(o_wr_data), 64'(row));
    endtask

    initial begin
        #1;
        chk("reset_ready", {63'd0, o_ready}, 64'd0);
        chk("reset_wr_en", {63'd0, o_wr_en}, 64'd0);
        chk("reset_busy", {63'd0, o_busy}, 64'd0);
        chk("reset_done", {63'd0, o_done}, 64'd0);
        chk("reset_addr", 64'(o_wr_addr), 64'd0);
        chk("reset_data", 64'(o_wr_data), 64'd0);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        step();

        // Sequential bytes, valid held high.
        run_load(5, 2, 1'b1, 1'b0, -1, -1, 1'b0);
        chk("seq_row1_literal", 64'(o_wr_data), 64'h0C0B0A090807);
        // Zero rows.
        run_load(9, 0, 1'b0, 1'b0, -1, -1, 1'b0);
        // Address wrap.
        run_load(127, 2, 1'b0, 1'b0, -1, -1, 1'b0);
        // Same data with random gaps.
        run_load(5, 2, 1'b1, 1'b1, -1, -1, 1'b0);
        chk("gap_row1_literal", 64'(o_wr_data), 64'h0C0B0A090807);
        // Abort after three bytes, then a fresh single-row load.
        run_load(40, 2, 1'b0, 1'b1, 3, -1, 1'b0);
        run_load(0, 1, 1'b0, 1'b0, -1, -1, 1'b0);
        // Reset during the second row's write, with a start pulse while busy.
        run_load(20, 2, 1'b0, 1'b0, -1, 1, 1'b1);
        // Random loads.
        for (int n = 0; n < 6; n++) begin
            run_load(int'($urandom_range(0, 127)), int'($urandom_range(1, 4)), 1'b0,
                     1'b1, -1, -1, 1'b0);
        end

        repeat (4) step();
        chk("pending_writes", 64'(exp_wr.size()), 64'd0);
        chk("pending_done", 64'(exp_done.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
